// File: rtl/vga_mem_pkg.sv
// -----------------------------------------------------------------------------
// vga_mem_pkg
// Shared definitions for the VGA frame-buffer arbiter: host FSM state
// encoding, default geometry / bus widths and the derived frame size.
// -----------------------------------------------------------------------------
package vga_mem_pkg;

  localparam int DEF_DATA_W = 12;   // RGB444 pixel word
  localparam int DEF_ADDR_W = 19;   // enough for 640*480 words
  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;

  localparam int unsigned FB_SIZE = DEF_H_RES * DEF_V_RES;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOST_BUSY = 2'd1,
    S_HOST_DONE = 2'd2
  } host_state_t;

endpackage : vga_mem_pkg

// File: rtl/vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// vga_mem_arbiter
// Single-port frame-buffer arbiter between the VGA display scan and one host
// port. Display fetches have absolute priority and fixed latency
// (pix_tick at t -> mem_en at t+1 -> rgb visible at t+3); the host gets every
// memory cycle the display leaves free (issue at c -> host_ack at c+2).
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   pix_tick              : one-cycle pixel strobe (>= 2 clk apart)
//   video_on, pixel_x/y   : scan position from vga_core, sampled on pix_tick
//   rgb                   : registered pixel to the DAC
//   host_req/we/addr/wdata: host request, held until host_ack
//   host_ack/err/rdata    : completion pulse, out-of-range flag, read data
//   mem_en/we/addr/wdata  : single-port synchronous RAM command
//   mem_rdata             : RAM read data, valid the cycle after a read
//   fetch_overrun         : sticky, pix_tick arrived with a fetch pending
// -----------------------------------------------------------------------------
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_tick,
  input  logic              video_on,
  input  logic [11:0]       pixel_x,
  input  logic [11:0]       pixel_y,
  output logic [DATA_W-1:0] rgb,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_err,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_overrun
);

  localparam int unsigned FB_WORDS = H_RES * V_RES;

  host_state_t       r_state, w_state_nxt;
  logic              r_disp_pend;
  logic [ADDR_W-1:0] r_disp_addr;
  logic              r_tick_d1, r_tick_d2;   // pixel pipeline, aligned to the fetch
  logic              r_on_d1,   r_on_d2;
  logic [DATA_W-1:0] r_rgb;
  logic              r_host_we;
  logic              r_host_oor;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_overrun;

  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_host_oor;
  logic              w_host_issue;

  // Truncation to ADDR_W is intentional: the multiply wraps like the address bus.
  assign w_disp_addr = ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x);
  assign w_host_oor  = (32'(host_addr) >= FB_WORDS);

  // ---------------------------------------------------------------------------
  // Arbitration and host FSM next state. The memory command is combinational
  // so a pending display fetch goes out the cycle after pix_tick. rst_n gates
  // the host grant so a request held through reset never reaches memory.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt  = r_state;
    w_host_issue = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    if (r_disp_pend) begin
      mem_en   = 1'b1;
      mem_addr = r_disp_addr;
    end else if (r_state == S_IDLE && host_req && rst_n) begin
      w_host_issue = 1'b1;
      if (!w_host_oor) begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_we ? host_wdata : '0;
      end
    end

    unique case (r_state)
      S_IDLE:      if (w_host_issue) w_state_nxt = S_HOST_BUSY;
      S_HOST_BUSY: w_state_nxt = S_HOST_DONE;
      S_HOST_DONE: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_disp_pend  <= 1'b0;
      r_disp_addr  <= '0;
      r_tick_d1    <= 1'b0;
      r_tick_d2    <= 1'b0;
      r_on_d1      <= 1'b0;
      r_on_d2      <= 1'b0;
      r_rgb        <= '0;
      r_host_we    <= 1'b0;
      r_host_oor   <= 1'b0;
      r_host_rdata <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // A pending fetch is always issued in the cycle it is visible, so the
      // flag only needs to reflect this cycle's tick.
      r_disp_pend <= pix_tick & video_on;
      if (pix_tick && video_on) r_disp_addr <= w_disp_addr;
      if (pix_tick && r_disp_pend) r_overrun <= 1'b1;

      // Two-stage marker pipeline lines up with the RAM read latency; a blank
      // tick travels the same path and produces a zero pixel.
      r_tick_d1 <= pix_tick;
      r_on_d1   <= video_on;
      r_tick_d2 <= r_tick_d1;
      r_on_d2   <= r_on_d1;
      if (r_tick_d2) r_rgb <= r_on_d2 ? mem_rdata : '0;

      if (w_host_issue) begin
        r_host_we  <= host_we;
        r_host_oor <= w_host_oor;
      end
      if (r_state == S_HOST_BUSY)
        r_host_rdata <= (!r_host_we && !r_host_oor) ? mem_rdata : '0;
    end
  end

  assign rgb           = r_rgb;
  assign host_ack      = (r_state == S_HOST_DONE);
  assign host_err      = host_ack & r_host_oor;
  assign host_rdata    = r_host_rdata;
  assign fetch_overrun = r_overrun;

endmodule : vga_mem_arbiter

// File: tb/tb_vga_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_mem_arbiter
// Directed self-checking bench for vga_mem_arbiter with a behavioural
// single-port synchronous RAM (1-cycle read latency).
// -----------------------------------------------------------------------------
module tb_vga_mem_arbiter;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 19;

  logic              clk;
  logic              rst_n;
  logic              pix_tick;
  logic              video_on;
  logic [11:0]       pixel_x;
  logic [11:0]       pixel_y;
  logic [DATA_W-1:0] rgb;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_err;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              fetch_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  vga_mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_RES(640), .V_RES(480)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_tick     (pix_tick),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .rgb          (rgb),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_err     (host_err),
    .host_rdata   (host_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fetch_overrun(fetch_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_start(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  initial begin
    rst_n = 1'b0; pix_tick = 1'b0; video_on = 1'b0;
    pixel_x = '0; pixel_y = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
    ram[1285] = 12'hABC;   // y=2, x=5
    ram[0]    = 12'h5A5;   // y=0, x=0

    // ---------------- reset state
    repeat (3) cyc();
    #1;
    check("rst_rgb",     32'(rgb), 32'h0);
    check("rst_mem_en",  32'(mem_en), 32'h0);
    check("rst_ack",     32'(host_ack), 32'h0);
    check("rst_err",     32'(host_err), 32'h0);
    check("rst_rdata",   32'(host_rdata), 32'h0);
    check("rst_overrun", 32'(fetch_overrun), 32'h0);
    rst_n = 1'b1;
    cyc(); cyc();

    // ---------------- display fetch: tick at t, x=5 y=2
    pix_tick = 1'b1; video_on = 1'b1; pixel_x = 12'd5; pixel_y = 12'd2;
    #1 check("disp_t0_mem_en", 32'(mem_en), 32'h0);
    cyc(); pix_tick = 1'b0;
    #1;
    check("disp_t1_mem_en",   32'(mem_en), 32'h1);
    check("disp_t1_mem_we",   32'(mem_we), 32'h0);
    check("disp_t1_mem_addr", 32'(mem_addr), 32'd1285);
    cyc(); #1 check("disp_t2_rgb", 32'(rgb), 32'h0);
    cyc(); #1 check("disp_t3_rgb", 32'(rgb), 32'hABC);

    // ---------------- blank tick
    pix_tick = 1'b1; video_on = 1'b0;
    cyc(); pix_tick = 1'b0;
    #1 check("blank_t1_mem_en", 32'(mem_en), 32'h0);
    cyc(); #1 check("blank_t2_rgb", 32'(rgb), 32'hABC);
    cyc(); #1 check("blank_t3_rgb", 32'(rgb), 32'h0);
    cyc();

    // ---------------- host write addr 100 <= 0x123
    host_start(1'b1, 19'd100, 12'h123);
    #1;
    check("wr_c0_mem_en",    32'(mem_en), 32'h1);
    check("wr_c0_mem_we",    32'(mem_we), 32'h1);
    check("wr_c0_mem_addr",  32'(mem_addr), 32'd100);
    check("wr_c0_mem_wdata", 32'(mem_wdata), 32'h123);
    check("wr_c0_ack",       32'(host_ack), 32'h0);
    cyc(); #1 check("wr_c1_ack", 32'(host_ack), 32'h0);
    cyc(); #1;
    check("wr_c2_ack", 32'(host_ack), 32'h1);
    check("wr_c2_err", 32'(host_err), 32'h0);
    host_req = 1'b0;
    cyc(); #1 check("wr_c3_ack", 32'(host_ack), 32'h0);

    // ---------------- host read addr 100
    host_start(1'b0, 19'd100, 12'h000);
    #1 check("rd_c0_mem_we", 32'(mem_we), 32'h0);
    cyc(); cyc(); #1;
    check("rd_c2_ack",   32'(host_ack), 32'h1);
    check("rd_c2_rdata", 32'(host_rdata), 32'h123);
    host_req = 1'b0;
    cyc();

    // ---------------- out-of-range write to 307200
    host_start(1'b1, 19'd307200, 12'hFFF);
    #1 check("oor_c0_mem_en", 32'(mem_en), 32'h0);
    cyc(); #1;
    check("oor_c1_mem_en", 32'(mem_en), 32'h0);
    check("oor_c1_ack",    32'(host_ack), 32'h0);
    cyc(); #1;
    check("oor_c2_ack",   32'(host_ack), 32'h1);
    check("oor_c2_err",   32'(host_err), 32'h1);
    check("oor_c2_rdata", 32'(host_rdata), 32'h0);
    host_req = 1'b0;
    cyc();

    // ---------------- simultaneous tick (x=0,y=0) and host write 200 in IDLE
    pix_tick = 1'b1; video_on = 1'b1; pixel_x = 12'd0; pixel_y = 12'd0;
    host_start(1'b1, 19'd200, 12'h456);
    #1;
    check("sim_c0_mem_addr", 32'(mem_addr), 32'd200);
    check("sim_c0_mem_we",   32'(mem_we), 32'h1);
    cyc(); pix_tick = 1'b0;
    #1;
    check("sim_c1_mem_addr", 32'(mem_addr), 32'd0);
    check("sim_c1_mem_we",   32'(mem_we), 32'h0);
    cyc(); #1 check("sim_c2_ack", 32'(host_ack), 32'h1);
    host_req = 1'b0;
    cyc(); #1 check("sim_c3_rgb", 32'(rgb), 32'h5A5);
    cyc();

    // ---------------- collision: tick at c-1, host read request rises at c
    pix_tick = 1'b1; video_on = 1'b1; pixel_x = 12'd5; pixel_y = 12'd2;
    #1 check("col_cm1_mem_en", 32'(mem_en), 32'h0);
    cyc(); pix_tick = 1'b0;
    host_start(1'b0, 19'd100, 12'h000);
    #1;
    check("col_c0_mem_addr", 32'(mem_addr), 32'd1285);
    check("col_c0_mem_we",   32'(mem_we), 32'h0);
    cyc(); #1;
    check("col_c1_mem_en",   32'(mem_en), 32'h1);
    check("col_c1_mem_addr", 32'(mem_addr), 32'd100);
    check("col_c1_rgb",      32'(rgb), 32'h5A5);
    cyc(); #1;
    check("col_c2_rgb", 32'(rgb), 32'hABC);
    check("col_c2_ack", 32'(host_ack), 32'h0);
    cyc(); #1;
    check("col_c3_ack",   32'(host_ack), 32'h1);
    check("col_c3_rdata", 32'(host_rdata), 32'h123);
    host_req = 1'b0;
    cyc(); cyc();

    // ---------------- overrun: two ticks one cycle apart
    pix_tick = 1'b1; video_on = 1'b1;
    cyc();
    #1 check("ovr_t1_overrun", 32'(fetch_overrun), 32'h0);
    cyc(); pix_tick = 1'b0;
    #1 check("ovr_t2_overrun", 32'(fetch_overrun), 32'h1);
    repeat (3) cyc();
    #1 check("ovr_sticky", 32'(fetch_overrun), 32'h1);

    // ---------------- reset in the middle of a host read
    host_start(1'b0, 19'd100, 12'h000);
    cyc();                       // FSM now in S_HOST_BUSY
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",     32'(host_ack), 32'h0);
    check("mid_rst_mem_en",  32'(mem_en), 32'h0);
    check("mid_rst_rgb",     32'(rgb), 32'h0);
    check("mid_rst_rdata",   32'(host_rdata), 32'h0);
    check("mid_rst_overrun", 32'(fetch_overrun), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("in_rst_ack",    32'(host_ack), 32'h0);
      check("in_rst_mem_en", 32'(mem_en), 32'h0);
    end
    rst_n = 1'b1; host_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("post_rst_ack", 32'(host_ack), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vga_mem_arbiter
